// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } if_state_e;

    localparam logic [31:0] IF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] IF_EXC_VECTOR = 32'h0000_0080;
    localparam logic [31:0] IF_NOP_WORD   = 32'h2008_0000;

endpackage

// File: rtl/if_pc_unit_if.sv
// Redirect/stall inputs and fetch-address outputs of the PC unit.
interface if_pc_unit_if;

    logic        pc_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] pc_out;
    logic [31:0] pc_add_out;
    logic        if_flush;
    logic        fetch_valid;
    logic        misalign_err;
    logic [31:0] misalign_epc;
    logic [31:0] fetch_count;

    modport master (
        output pc_stall, branch_taken, branch_target,
        output jump, jump_target, jr, jr_target,
        input  pc_out, pc_add_out, if_flush, fetch_valid,
        input  misalign_err, misalign_epc, fetch_count
    );

    modport slave (
        input  pc_stall, branch_taken, branch_target,
        input  jump, jump_target, jr, jr_target,
        output pc_out, pc_add_out, if_flush, fetch_valid,
        output misalign_err, misalign_epc, fetch_count
    );

endinterface

// File: rtl/pc_next_sel.sv
// Redirect priority mux: branch > jr > jump, falling back to a held target.
module pc_next_sel (
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        use_pend,
    input  logic [31:0] pend_target,
    output logic        redirect,
    output logic [31:0] target,
    output logic        misalign
);

    always_comb begin
        redirect = branch_taken | jr | jump;
        if (branch_taken)
            target = branch_target;
        else if (jr)
            target = jr_target;
        else if (jump)
            target = jump_target;
        else if (use_pend)
            target = pend_target;
        else
            target = 32'd0;
        misalign = (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/if_pc_unit.sv
// PC register, next-PC selection and stall-held redirects for fetch.
module if_pc_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = IF_EXC_VECTOR
) (
    input  logic        clock,
    input  logic        reset,
    if_pc_unit_if.slave bus
);

    if_state_e   state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pend, pend_nxt;
    logic        err, err_nxt;
    logic [31:0] epc, epc_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic        commit;
    logic        redir;
    logic [31:0] sel_target;
    logic        misalign;

    pc_next_sel u_sel (
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .jump          (bus.jump),
        .jump_target   (bus.jump_target),
        .jr            (bus.jr),
        .jr_target     (bus.jr_target),
        .use_pend      (state == PEND),
        .pend_target   (pend),
        .redirect      (redir),
        .target        (sel_target),
        .misalign      (misalign)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BOOT;
            pc    <= RESET_PC;
            pend  <= 32'd0;
            err   <= 1'b0;
            epc   <= 32'd0;
            cnt   <= 32'd0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            pend  <= pend_nxt;
            err   <= err_nxt;
            epc   <= epc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        pend_nxt  = pend;
        err_nxt   = err;
        epc_nxt   = epc;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        unique case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (redir && bus.pc_stall) begin
                    pend_nxt  = sel_target;
                    state_nxt = PEND;
                end else if (redir) begin
                    commit = 1'b1;
                end else if (!bus.pc_stall) begin
                    pc_nxt  = pc + 32'd4;
                    cnt_nxt = cnt + 32'd1;
                end
            end
            PEND: begin
                if (redir)
                    pend_nxt = sel_target;
                if (!bus.pc_stall) begin
                    commit    = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase
        // Misaligned targets trap; only the first offender is recorded.
        if (commit) begin
            cnt_nxt = cnt + 32'd1;
            if (misalign) begin
                pc_nxt  = EXC_VECTOR;
                err_nxt = 1'b1;
                if (!err)
                    epc_nxt = sel_target;
            end else begin
                pc_nxt = sel_target;
            end
        end
    end

    assign bus.pc_out       = pc;
    assign bus.pc_add_out   = pc + 32'd4;
    assign bus.if_flush     = commit;
    assign bus.fetch_valid  = (state != BOOT);
    assign bus.misalign_err = err;
    assign bus.misalign_epc = epc;
    assign bus.fetch_count  = cnt;

endmodule
